// File: rtl/reg_store_seq_if.sv
// Memory write port of the register store sequencer.
// Write request with address/data held until acknowledged.
interface reg_store_seq_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;

  modport master (
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_ack
  );

  modport slave (
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack
  );
endinterface

// File: rtl/reg_store_seq.sv
// Register store sequencer: walks a register mask (plus res)
// and writes each selected word to consecutive memory addresses.
module reg_store_seq #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        mask,
  input  logic              store_res,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [2:0]        reg_sel,
  input  logic [DATA_W-1:0] reg_val,
  input  logic [DATA_W-1:0] res_val,
  reg_store_seq_if.master   mem,
  output logic              busy,
  output logic              done,
  output logic [3:0]        count
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [7:0]        pend;
  logic              res_pend;
  logic [ADDR_W-1:0] ptr;
  logic [2:0]        sel_q;
  logic [2:0]        k;
  logic              any;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // lowest pending register index
  always_comb begin
    k = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pend[i]) k = 3'(i);
    end
  end

  assign any = |pend;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = SCAN;
      SCAN:  state_nx = (any || res_pend) ? WRITE : DONE;
      WRITE: if (mem.mem_ack) state_nx = SCAN;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // request latch, word capture and write bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      pend     <= '0;
      res_pend <= 1'b0;
      ptr      <= '0;
      sel_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      count    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            pend     <= mask;
            res_pend <= store_res;
            ptr      <= base_addr;
            count    <= '0;
          end
        end
        SCAN: begin
          if (any) begin
            wdata_q <= reg_val;
            addr_q  <= ptr;
            wr_q    <= 1'b1;
            pend[k] <= 1'b0;
            sel_q   <= k;
          end else if (res_pend) begin
            wdata_q  <= res_val;
            addr_q   <= ptr;
            wr_q     <= 1'b1;
            res_pend <= 1'b0;
          end
        end
        WRITE: begin
          if (mem.mem_ack) begin
            wr_q  <= 1'b0;
            ptr   <= ptr + ADDR_W'(1);
            count <= (count == 4'd9) ? count : count + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign reg_sel       = (state == SCAN && any) ? k : sel_q;
  assign mem.mem_wr    = wr_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign busy          = (state == SCAN) || (state == WRITE);
  assign done          = (state == DONE);

endmodule

// File: tb/tb_reg_store_seq.sv
// Directed bench for reg_store_seq: register file model,
// write logger and ack responder driven per cycle.
module tb_reg_store_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  mask;
  logic        store_res;
  logic [15:0] base_addr;
  logic [2:0]  reg_sel;
  logic [15:0] reg_val;
  logic [15:0] res_val;
  logic        busy;
  logic        done;
  logic [3:0]  count;
  logic [15:0] rf [8];

  reg_store_seq_if #(.ADDR_W(16), .DATA_W(16)) mem ();

  reg_store_seq #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mask      (mask),
    .store_res (store_res),
    .base_addr (base_addr),
    .reg_sel   (reg_sel),
    .reg_val   (reg_val),
    .res_val   (res_val),
    .mem       (mem.master),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  assign reg_val = rf[reg_sel];

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] wa [$];
  logic [15:0] wd [$];

  // log every accepted write
  always @(posedge clk) begin
    if (!reset && mem.mem_wr && mem.mem_ack) begin
      wa.push_back(mem.mem_addr);
      wd.push_back(mem.mem_wdata);
    end
  end

  int          edge_n;
  int          done_cnt;
  int          done_edge;
  int          busy_cnt;
  int          busy_first;
  int          busy_last;
  int          age;
  int          max_age;
  bit          slow;
  logic [15:0] hold_a;
  logic [15:0] hold_d;

  task automatic step();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    if (done) begin
      done_cnt++;
      done_edge = edge_n;
    end
    if (busy) begin
      busy_cnt++;
      if (busy_first < 0) busy_first = edge_n;
      busy_last = edge_n;
    end
    if (mem.mem_wr) begin
      age++;
      if (age > max_age) max_age = age;
      if (age > 1) begin
        check("wr_hold_addr", mem.mem_addr, hold_a);
        check("wr_hold_data", mem.mem_wdata, hold_d);
      end
      hold_a = mem.mem_addr;
      hold_d = mem.mem_wdata;
    end else begin
      age = 0;
    end
    mem.mem_ack = slow ? (!mem.mem_wr || age >= 3) : 1'b1;
  endtask

  task automatic clear_obs(input bit s);
    wa.delete();
    wd.delete();
    done_cnt   = 0;
    done_edge  = -1;
    busy_cnt   = 0;
    busy_first = -1;
    busy_last  = -1;
    age        = 0;
    max_age    = 0;
    slow       = s;
    mem.mem_ack = 1'b1;
  endtask

  task automatic run(input logic [7:0] m, input logic sr,
                     input logic [15:0] b, input bit s,
                     input int poke);
    clear_obs(s);
    mask      = m;
    store_res = sr;
    base_addr = b;
    start     = 1'b1;
    edge_n    = -1;
    step();
    start     = 1'b0;
    mask      = 8'hA5;
    base_addr = 16'hDEAD;
    store_res = ~sr;
    for (int i = 0; i < 200 && done_edge < 0; i++) begin
      step();
      if (edge_n == poke) begin
        start = 1'b1;
        rf[1] = 16'hBEEF;
      end else if (edge_n == poke + 1) begin
        start = 1'b0;
      end
    end
    if (done_edge < 0) check("timeout", 0, 1);
    step();
    step();
    check("idle_busy", busy, 1'b0);
    check("done_pulses", done_cnt, 1);
  endtask

  logic [15:0] ea [$];
  logic [15:0] ed [$];

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, wa.size(), ea.size());
    for (int i = 0; i < ea.size(); i++) begin
      check({tag, "_addr"}, (i < wa.size()) ? wa[i] : 16'hxxxx, ea[i]);
      check({tag, "_data"}, (i < wd.size()) ? wd[i] : 16'hxxxx, ed[i]);
    end
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    mask        = 8'h00;
    store_res   = 1'b0;
    base_addr   = 16'h0000;
    res_val     = 16'h0000;
    mem.mem_ack = 1'b0;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0F00 + 16'(i);
    repeat (3) @(negedge clk);
    check("rst_wr", mem.mem_wr, 1'b0);
    check("rst_addr", mem.mem_addr, 16'h0000);
    check("rst_wdata", mem.mem_wdata, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_count", count, 4'd0);
    check("rst_sel", reg_sel, 3'd0);
    reset = 1'b0;
    @(negedge clk);

    // two sparse registers, ack tied high
    rf[0] = 16'h1111;
    rf[2] = 16'h2222;
    run(8'b0000_0101, 1'b0, 16'h0100, 1'b0, -100);
    ea = '{16'h0100, 16'h0101};
    ed = '{16'h1111, 16'h2222};
    check_writes("t1");
    check("t1_count", count, 4'd2);
    check("t1_done_edge", done_edge, 5);
    check("t1_busy_first", busy_first, 0);
    check("t1_busy_last", busy_last, 4);
    check("t1_busy_cnt", busy_cnt, 5);

    // all registers plus res, address wrap
    for (int i = 0; i < 8; i++) rf[i] = 16'hA050 + 16'(i * 257);
    res_val = 16'h7E57;
    run(8'hFF, 1'b1, 16'hFFFC, 1'b0, -100);
    ea = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000,
           16'h0001, 16'h0002, 16'h0003, 16'h0004};
    ed = '{16'hA050, 16'hA151, 16'hA252, 16'hA353, 16'hA454,
           16'hA555, 16'hA656, 16'hA757, 16'h7E57};
    check_writes("t2");
    check("t2_count", count, 4'd9);
    check("t2_done_edge", done_edge, 19);

    // slow ack with stray acks while idle/scanning
    rf[7] = 16'h7777;
    run(8'b1000_0000, 1'b0, 16'h4000, 1'b1, -100);
    ea = '{16'h4000};
    ed = '{16'h7777};
    check_writes("t3");
    check("t3_count", count, 4'd1);
    check("t3_hold_cycles", max_age, 3);
    check("t3_done_edge", done_edge, 5);

    // empty request
    run(8'h00, 1'b0, 16'h0500, 1'b0, -100);
    check("t4_nwr", wa.size(), 0);
    check("t4_wr_seen", max_age, 0);
    check("t4_done_edge", done_edge, 1);
    check("t4_count", count, 4'd0);

    // reset during the second word's write
    rf[0] = 16'h0A0A;
    rf[1] = 16'h0B0B;
    clear_obs(1'b0);
    mask      = 8'b0000_0011;
    store_res = 1'b0;
    base_addr = 16'h0200;
    start     = 1'b1;
    edge_n    = -1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("t5_pre_wr", mem.mem_wr, 1'b1);
    check("t5_pre_addr", mem.mem_addr, 16'h0201);
    reset = 1'b1;
    step();
    check("t5_wr", mem.mem_wr, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_count", count, 4'd0);
    check("t5_done", done, 1'b0);
    check("t5_addr", mem.mem_addr, 16'h0000);
    reset = 1'b0;
    step();
    step();
    step();
    check("t5_no_done", done_cnt, 0);
    check("t5_nwr", wa.size(), 1);
    run(8'b0000_0011, 1'b0, 16'h0300, 1'b0, -100);
    ea = '{16'h0300, 16'h0301};
    ed = '{16'h0A0A, 16'h0B0B};
    check_writes("t5b");
    check("t5b_count", count, 4'd2);

    // restart ignored while busy, r1 changed after capture
    rf[1] = 16'h1234;
    rf[2] = 16'h2345;
    run(8'b0000_0110, 1'b0, 16'h0600, 1'b0, 1);
    ea = '{16'h0600, 16'h0601};
    ed = '{16'h1234, 16'h2345};
    check_writes("t6");
    check("t6_count", count, 4'd2);
    check("t6_done_edge", done_edge, 5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/reg_store_seq.md
# reg_store_seq

Multi-cycle store sequencer that reads the CPU register file and writes its contents to data memory. It drives the register file's 3-bit register select, samples the selected register value and the `res` accumulator, and emits one memory write per selected word through a write/acknowledge handshake. Used for context save and register dumps; it is the reader counterpart of the register file's write ports (ALU result, copy-out, memory load).

## Interface

Parameters:
- ADDR_W, 16, memory address width; `base_addr` and `mem_addr` wrap modulo 2^ADDR_W.
- DATA_W, 16, register, `res` and memory data width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- mask  in  8  bit i set means store reg i; latched when start is accepted.
- store_res  in  1  also store `res` after the registers; latched when start is accepted.
- base_addr  in  ADDR_W  address of the first word written; latched when start is accepted.
- reg_sel  out  3  register select to the register file.
- reg_val  in  DATA_W  selected register value, combinational from the register file.
- res_val  in  DATA_W  current `res` value.
- mem_wr  out  1  write request.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  DATA_W  write data.
- mem_ack  in  1  memory accepted the write; meaningful only while mem_wr=1.
- busy  out  1  high in SCAN and WRITE.
- done  out  1  one-cycle completion pulse.
- count  out  4  words written in the current or last operation.

## Operation

- States: IDLE, SCAN, WRITE, DONE.
- IDLE
  - On start=1, latch mask into `pend`, store_res into `res_pend`, and base_addr into `ptr`.
  - Clear count and go to SCAN.
- SCAN
  - Pick the lowest set bit k of `pend`. Drive reg_sel=k combinationally.
  - On the edge: mem_wdata<=reg_val, mem_addr<=ptr, mem_wr<=1, clear pend[k], go to WRITE.
  - Clear bits cost no cycles.
  - If `pend`=0 and `res_pend`=1: mem_wdata<=res_val, mem_addr<=ptr, mem_wr<=1, clear res_pend, go to WRITE.
  - If both are empty, go to DONE.
- WRITE
  - Hold mem_wr, mem_addr and mem_wdata stable until mem_ack=1 is sampled.
  - On that edge: mem_wr<=0, ptr<=ptr+1 (wraps), count<=count+1, go to SCAN.
- DONE: done=1 for exactly this cycle, then IDLE.
- Write order is ascending register index, then `res`. Addresses are consecutive from base_addr.
- start while not in IDLE is ignored; there is no queueing.
- mem_ack while mem_wr=0 is ignored.
- reg_sel holds its last driven value outside SCAN.
- The stored value is whatever is present at the SCAN capture edge. Register-file updates on the falling edge before that edge are included. Later changes do not affect a word already captured.

## Timing

- Reset values: state=IDLE, reg_sel=0, mem_wr=0, mem_addr=0, mem_wdata=0, busy=0, done=0, count=0.
- Edges are numbered with the start-accept edge as edge 0.
- Edge 0: start accepted; SCAN from the next cycle.
- Per word: 1 SCAN cycle plus W WRITE cycles, where W≥1 is the number of cycles until mem_ack is sampled.
- With mem_ack tied high, N words take 2N cycles. done is high in the cycle after edge 2N+1.
- Empty request (mask=0, store_res=0): SCAN → DONE. done is high in the cycle after edge 1, with no mem_wr.
- Reset mid-operation in any state:
  - Next cycle shows reset values and mem_wr drops immediately.
  - No done pulse; latched mask and pointer are discarded.
  - A write that was pending but not acked is abandoned.
- count maxes at 9 and never wraps.

## Test plan

- mask=8'b00000101, store_res=0, base=0x0100, r0=0x1111, r2=0x2222, ack tied high → writes (0x0100,0x1111) then (0x0101,0x2222). count=2. Single done pulse in the cycle after edge 5. busy high for cycles 1–5.
- mask=0xFF, store_res=1, base=0xFFFC, ack high → 9 writes at 0xFFFC..0xFFFF then 0x0000..0x0004. r0..r7 then res_val last. count=9.
- mask=8'b10000000, ack asserted 3 cycles after mem_wr rises → mem_wr/mem_addr/mem_wdata stable for all 3 cycles. Exactly one write of r7. Stray ack pulses while mem_wr=0 have no effect.
- mask=0, store_res=0 → mem_wr never asserts. done in the cycle after edge 1. count=0.
- reset asserted during WRITE of the second word → next cycle mem_wr=0, busy=0, count=0, no done. A new start then runs from base_addr correctly.
- start pulsed while busy, and r1 changed after its capture edge → second start ignored. Memory holds the captured (old) r1 value.
